dmem_access_arbiter: RTL

Shares the single write/read port of the 16×8 data memory between the CPU datapath and a host/debug port (board loader, PONG score injector). The CPU owns the port by default; host transactions are slotted into CPU-idle cycles or, after a bounded wait, forced in by stalling the CPU for one cycle. Sits between the CPU control unit, the host interface and the data memory instance.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_access_arbiter_if.sv | 41 ++++
 rtl/dmem_starve_counter.sv | 37 +++
 rtl/dmem_access_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory port arbiter.
package dmem_arb_pkg;

   localparam int unsigned AddrW          = 4;
   localparam int unsigned DataW          = 8;
   localparam int unsigned StarveLimitDef = 4;

   typedef enum logic [1:0] {
      StInit = 2'd0,
      StIdle = 2'd1,
      StHost = 2'd2,
      StAck  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/dmem_access_arbiter_if.sv
// CPU, host and memory-side signals of the shared data-memory port.
interface dmem_access_arbiter_if;
   import dmem_arb_pkg::*;

   logic             cpu_write_enable;
   logic [AddrW-1:0] cpu_write_select;
   logic [AddrW-1:0] cpu_read_select;
   logic [DataW-1:0] cpu_write_data;
   logic             cpu_mem_active;
   logic             cpu_stall;

   logic             host_req;
   logic             host_write;
   logic [AddrW-1:0] host_addr;
   logic [DataW-1:0] host_wdata;
   logic             host_ack;
   logic [DataW-1:0] host_rdata;

   logic             dmem_write_enable;
   logic [AddrW-1:0] dmem_write_select;
   logic [AddrW-1:0] dmem_read_select;
   logic [DataW-1:0] dmem_input;
   logic [DataW-1:0] dmem_output;

   // Arbiter side.
   modport slave (
      input  cpu_write_enable, cpu_write_select, cpu_read_select, cpu_write_data, cpu_mem_active,
      input  host_req, host_write, host_addr, host_wdata, dmem_output,
      output cpu_stall, host_ack, host_rdata,
      output dmem_write_enable, dmem_write_select, dmem_read_select, dmem_input
   );

   // CPU/host/memory environment side.
   modport master (
      output cpu_write_enable, cpu_write_select, cpu_read_select, cpu_write_data, cpu_mem_active,
      output host_req, host_write, host_addr, host_wdata, dmem_output,
      input  cpu_stall, host_ack, host_rdata,
      input  dmem_write_enable, dmem_write_select, dmem_read_select, dmem_input
   );

endinterface

// File: rtl/dmem_starve_counter.sv
// Saturating wait counter for a host request stuck behind CPU memory traffic.
module dmem_starve_counter #(
   parameter int unsigned Limit = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam logic [3:0] LimitC = 4'(Limit);

   logic [3:0] cnt_q, cnt_d;

   // Clear has priority; increment stops at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LimitC)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == LimitC);

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares the data-memory port between the CPU (default owner) and the host port.
module dmem_access_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned StarveLimit = StarveLimitDef
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   dmem_access_arbiter_if.slave  bus
);

   arb_state_e       state_q, state_d;
   logic [DataW-1:0] host_rdata_q, host_rdata_d;
   logic             in_idle;
   logic             go_host;
   logic             at_limit;
   logic             starve_inc;
   logic             starve_clr;

   assign in_idle    = (state_q == StIdle);
   // A waiting host may cut in once it has waited out the starvation limit.
   assign go_host    = bus.host_req & (~bus.cpu_mem_active | at_limit);
   assign starve_inc = in_idle & bus.host_req & bus.cpu_mem_active;
   assign starve_clr = ~bus.host_req | (in_idle & go_host);

   dmem_starve_counter #(
      .Limit (StarveLimit)
   ) u_starve_counter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (starve_inc),
      .clr_i      (starve_clr),
      .at_limit_o (at_limit)
   );

   // State and captured host read data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StInit;
         host_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         host_rdata_q <= host_rdata_d;
      end
   end

   // Next-state and read-data capture.
   always_comb begin
      state_d      = state_q;
      host_rdata_d = host_rdata_q;
      unique case (state_q)
         StInit: state_d = StIdle;
         StIdle: if (go_host) state_d = StHost;
         StHost: begin
            state_d = StAck;
            if (!bus.host_write) host_rdata_d = bus.dmem_output;
         end
         StAck:  state_d = StIdle;
         default: state_d = StInit;
      endcase
   end

   // Port muxing: CPU passes straight through except during INIT and HOST.
   always_comb begin
      bus.cpu_stall         = 1'b0;
      bus.host_ack          = 1'b0;
      bus.dmem_write_enable = bus.cpu_write_enable;
      bus.dmem_write_select = bus.cpu_write_select;
      bus.dmem_read_select  = bus.cpu_read_select;
      bus.dmem_input        = bus.cpu_write_data;
      unique case (state_q)
         StInit: begin
            bus.cpu_stall         = 1'b1;
            bus.dmem_write_enable = 1'b0;
         end
         StHost: begin
            bus.cpu_stall         = 1'b1;
            bus.dmem_write_enable = bus.host_write;
            bus.dmem_write_select = bus.host_addr;
            bus.dmem_read_select  = bus.host_addr;
            bus.dmem_input        = bus.host_wdata;
         end
         StAck:  bus.host_ack = 1'b1;
         default: ;
      endcase
   end

   assign bus.host_rdata = host_rdata_q;

endmodule
